// File: rtl/imem_fetch_sequencer_if.sv
// imem_fetch_sequencer_if: instruction-memory port, redirect request and decode-side handshake.
interface imem_fetch_sequencer_if;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic [31:0] fetch_count;
   modport master (
      output imem_address, out_valid, out_instruction, out_pc, fetch_count,
      input  imem_instruction, redirect, redirect_pc, out_ready
   );
   modport slave (
      input  imem_address, out_valid, out_instruction, out_pc, fetch_count,
      output imem_instruction, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: owns the PC, fetches from combinational imem into a 2-entry FIFO drained by decode.
module imem_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   imem_fetch_sequencer_if.master  bus
);
   logic [31:0] pc;
   logic [31:0] buf_pc [2];
   logic [31:0] buf_instr [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  occ;
   logic [31:0] fetch_count;
   logic        out_valid, deq, enq;
   assign out_valid = occ != 2'd0;
   assign deq = out_valid & bus.out_ready;
   // a full buffer still accepts a fetch when the head leaves on the same edge
   assign enq = !bus.redirect & ((occ != 2'(DEPTH)) | deq);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= 2'd0;
         fetch_count <= '0;
         for (int i = 0; i < 2; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
         end
      end else if (bus.redirect) begin
         pc     <= {bus.redirect_pc[31:2], 2'b00};
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (enq) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= bus.imem_instruction;
            wr_ptr            <= ~wr_ptr;
            pc                <= pc + 32'd4;
            fetch_count       <= fetch_count + 32'd1;
         end
         if (deq) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, enq} - {1'b0, deq};
      end
   end
   assign bus.imem_address    = pc;
   assign bus.out_valid       = out_valid;
   assign bus.out_instruction = out_valid ? buf_instr[rd_ptr] : '0;
   assign bus.out_pc          = out_valid ? buf_pc[rd_ptr] : '0;
   assign bus.fetch_count     = fetch_count;
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: directed steps against a memory where word i holds i*3.
module tb_imem_fetch_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   imem_fetch_sequencer_if bus ();
   imem_fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   assign bus.imem_instruction = 32'(bus.imem_address[8:2]) * 32'd3;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic head(input string tag, input logic [31:0] p, input logic [31:0] ins);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_pc"}, bus.out_pc, p);
      chk({tag, "_instr"}, bus.out_instruction, ins);
   endtask
   initial begin
      bus.out_ready   = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_instr", bus.out_instruction, 32'd0);
      chk("rst_pc", bus.out_pc, 32'd0);
      chk("rst_count", bus.fetch_count, 32'd0);
      chk("rst_addr", bus.imem_address, 32'd0);
      step();
      step();
      // streaming with decode always ready
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step(); head("s0", 32'd0, 32'd0);
      step(); head("s1", 32'd4, 32'd3);
      step(); head("s2", 32'd8, 32'd6);
      step(); head("s3", 32'd12, 32'd9);
      chk("s_count", bus.fetch_count, 32'd4);
      // stall: buffer fills after two edges then PC holds
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      rst_n = 1'b1;
      step(); chk("st1_count", bus.fetch_count, 32'd1);
      step(); chk("st2_count", bus.fetch_count, 32'd2);
      chk("st2_addr", bus.imem_address, 32'h8);
      step(); step(); step();
      chk("st5_addr", bus.imem_address, 32'h8);
      chk("st5_count", bus.fetch_count, 32'd2);
      head("st5", 32'd0, 32'd0);
      bus.out_ready = 1'b1;
      step(); head("rs1", 32'd4, 32'd3);
      chk("rs1_count", bus.fetch_count, 32'd3);
      step(); head("rs2", 32'd8, 32'd6);
      chk("rs2_count", bus.fetch_count, 32'd4);
      // redirect with a full buffer
      bus.out_ready = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h43;
      step();
      bus.redirect = 1'b0;
      chk("rd_valid", 32'(bus.out_valid), 32'd0);
      chk("rd_pc0", bus.out_pc, 32'd0);
      chk("rd_addr", bus.imem_address, 32'h40);
      chk("rd_count", bus.fetch_count, 32'd4);
      step(); head("rd1", 32'h40, 32'd48);
      chk("rd1_count", bus.fetch_count, 32'd5);
      // redirect together with a dequeue at occupancy 1
      bus.out_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h100;
      step();
      bus.redirect = 1'b0;
      chk("rdq_valid", 32'(bus.out_valid), 32'd0);
      chk("rdq_count", bus.fetch_count, 32'd5);
      chk("rdq_addr", bus.imem_address, 32'h100);
      step(); head("rdq1", 32'h100, 32'd192);
      chk("rdq1_count", bus.fetch_count, 32'd6);
      // stream up to PC=0x20 then pulse reset between edges
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h10;
      step();
      bus.redirect = 1'b0;
      step(); step(); step(); step();
      head("pre_rst", 32'h1c, 32'd21);
      chk("pre_rst_addr", bus.imem_address, 32'h20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_addr", bus.imem_address, 32'd0);
      chk("ar_valid", 32'(bus.out_valid), 32'd0);
      chk("ar_instr", bus.out_instruction, 32'd0);
      chk("ar_pc", bus.out_pc, 32'd0);
      chk("ar_count", bus.fetch_count, 32'd0);
      #2;
      rst_n = 1'b1;
      step(); head("ar1", 32'd0, 32'd0);
      step(); head("ar2", 32'd4, 32'd3);
      chk("ar2_count", bus.fetch_count, 32'd2);
      // PC wrap at the top of the address space
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      chk("wr_valid", 32'(bus.out_valid), 32'd0);
      step(); head("wr1", 32'hFFFF_FFFC, 32'd381);
      step(); head("wr2", 32'h0, 32'd0);
      step(); head("wr3", 32'h4, 32'd3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Sequences the 128-word combinational instruction memory for the MIPS datapath. Owns the program counter, presents fetch addresses to the instruction memory, and captures returned instructions into a 2-entry fetch buffer. The buffer drains to decode over a valid/ready handshake. Branch/jump redirects arriving from later stages flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- DEPTH, 2: fetch buffer entries; fixed at 2, other values unsupported.
- Clk  in  1  single clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ImemAddress  out  32  fetch address to instruction memory; equals current PC (combinational from PC register).
- ImemInstruction  in  32  combinational read data for ImemAddress, valid in the same cycle.
- Redirect  in  1  flush-and-restart request, sampled at rising edge.
- RedirectPC  in  32  new fetch address when Redirect=1; bits [1:0] forced to 0 internally.
- OutValid  out  1  buffer head holds a valid instruction.
- OutReady  in  1  decode accepts head this cycle.
- OutInstruction  out  32  instruction at buffer head; 0 when empty.
- OutPC  out  32  PC of instruction at buffer head; 0 when empty.
- FetchCount  out  32  number of instructions enqueued since reset, wraps modulo 2^32.

## Operation
- State: PC register, 2-entry circular buffer (write ptr, read ptr, occupancy 0..2), FetchCount.
- Dequeue (deq) = OutValid & OutReady.
- Enqueue (enq) = !Redirect & (occupancy < 2 | deq). An enqueue writes {PC, ImemInstruction} into the buffer, sets PC <= PC + 4, and increments FetchCount.
- Full with simultaneous dequeue: enqueue is permitted, and occupancy stays 2.
- Redirect=1 takes priority over all other actions:
  - Buffer is emptied (occupancy <= 0, pointers reset to 0).
  - PC <= {RedirectPC[31:2], 2'b00}.
  - No enqueue this cycle, and FetchCount is not incremented.
  - A same-cycle deq is still considered consumed by decode, but the buffer ends empty regardless.
- PC arithmetic is 32-bit unsigned and wraps at 32'hFFFF_FFFC -> 0. The instruction memory uses only Address[8:2], so PC values above 0x1FC alias; the sequencer does not detect or flag this.
- Buffer order is strict FIFO. OutPC/OutInstruction always reflect the read-ptr entry.
- Reset: asserting Rst_n=0 at any time, including mid-drain or mid-redirect, immediately sets:
  - PC = RESET_PC
  - occupancy = 0
  - OutValid = 0
  - OutInstruction = 0
  - OutPC = 0
  - FetchCount = 0
  - all pointers 0
- No state machine beyond occupancy; the three occupancy values EMPTY/ONE/FULL transition as follows:
  - EMPTY: enq -> ONE.
  - ONE: enq&!deq -> FULL; deq&!enq -> EMPTY; otherwise stay.
  - FULL: deq (with enq) -> FULL; !deq -> FULL with enq blocked.
  - Any state: Redirect -> EMPTY.

## Timing
- ImemAddress changes only after a rising edge or on reset (PC is registered).
- Latency:
  - Reset release to first instruction: the first rising edge after Rst_n rises enqueues RESET_PC's instruction, and OutValid=1 after that edge.
  - Redirect: the edge with Redirect=1 loads the target, the next edge enqueues it, and OutValid=1 two edges after redirect sampling. This is a 1-cycle bubble.
- Throughput: 1 instruction/cycle with OutReady held high.
- Stall behaviour:
  - With OutReady=0, the buffer fills in 2 cycles, after which PC holds and ImemAddress is stable.
  - Restart after a stall has no bubble: deq and enq occur on the same edge.
- All outputs are registered or derived from registers; there are no combinational paths from OutReady, Redirect, or ImemInstruction to any output.

## Test plan
- Reset then OutReady=1 for 4 cycles, memory[i]=i*3 -> OutPC sequence 0,4,8,12 with OutInstruction 0,3,6,9, OutValid high from the first edge, FetchCount=4.
- OutReady=0 for 5 cycles after reset -> occupancy reaches 2 after 2 edges, ImemAddress holds 0x8, FetchCount=2. Raising OutReady then delivers PCs 0,4,8 back-to-back with no bubble.
- Redirect=1 with RedirectPC=0x43 while buffer is full -> buffer empty and OutValid=0 next cycle. The following edge gives OutPC=0x40, OutInstruction=memory[16]=48.
- Redirect and deq on the same edge with occupancy 1 -> OutValid=0 after the edge and FetchCount unchanged on that edge.
- Rst_n pulsed low asynchronously (between edges) mid-stream with PC=0x20 -> all outputs 0 immediately and ImemAddress=RESET_PC. Streaming resumes from RESET_PC after release.
- RedirectPC=32'hFFFF_FFFC, OutReady=1 -> OutPC sequence FFFF_FFFC, 0000_0000, 0000_0004, showing PC wraps without error.
